// File: rtl/regfile_wb_arb.sv
// Writeback arbiter for the single regfile write port: merges the ALU result stream
// with an in-order load FIFO. A starvation counter guarantees that queued loads retire.
module regfile_wb_arb #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_rd_i,
    input  logic [31:0] lsu_data_i,
    output logic        wen_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic [31:0] pending_mask_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [4:0]    rd_mem_q  [DEPTH];
    logic [31:0]   dat_mem_q [DEPTH];
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          wen_q, wen_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          q_nonempty, force_load, grant_alu, grant_q, push;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;
    logic [31:0]   pend;

    assign q_nonempty  = (count_q != '0);
    assign force_load  = q_nonempty && (starve_q == SW'(STARVE_LIMIT));
    assign alu_ready_o = !force_load;
    assign grant_alu   = alu_valid_i && !force_load;
    assign grant_q     = !grant_alu && q_nonempty;
    // Full queue blocks the LSU even if the head pops this cycle: ready is state-only.
    assign lsu_ready_o = (count_q != CW'(DEPTH));
    assign push        = lsu_valid_i && lsu_ready_o;

    assign sel_rd   = grant_alu ? alu_rd_i   : rd_mem_q[rptr_q];
    assign sel_data = grant_alu ? alu_data_i : dat_mem_q[rptr_q];

    always_comb begin
        rptr_d   = rptr_q;
        wptr_d   = wptr_q;
        count_d  = count_q + CW'(push) - CW'(grant_q);
        starve_d = starve_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (push)    wptr_d = wptr_q + PW'(1);
        if (grant_q) rptr_d = rptr_q + PW'(1);
        if (grant_q || !q_nonempty) begin
            starve_d = '0;
        end else if (grant_alu && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end
        if (grant_alu || grant_q) begin
            wen_d   = (sel_rd != 5'd0);
            waddr_d = (sel_rd != 5'd0) ? sel_rd   : 5'd0;
            wdata_d = (sel_rd != 5'd0) ? sel_data : 32'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= 5'd0;
            wdata_q  <= 32'd0;
        end else begin
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            rd_mem_q[wptr_q]  <= lsu_rd_i;
            dat_mem_q[wptr_q] <= lsu_data_i;
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        logic [PW-1:0] offs;
        pend = '0;
        offs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rptr_q;
            if ({1'b0, offs} < count_q) pend[rd_mem_q[i]] = 1'b1;
        end
        pend[0] = 1'b0;
    end

    assign wen_o          = wen_q;
    assign waddr_o        = waddr_q;
    assign wdata_o        = wdata_q;
    assign pending_mask_o = pend;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb with a small behavioural regfile on the write port.
module tb_regfile_wb_arb;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        alu_valid_i, lsu_valid_i;
    logic        alu_ready_o, lsu_ready_o;
    logic [4:0]  alu_rd_i, lsu_rd_i;
    logic [31:0] alu_data_i, lsu_data_i;
    logic        wen_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic [31:0] pending_mask_o;
    logic [31:0] rf [32];
    int          n_err = 0;
    int          n_chk = 0;

    regfile_wb_arb #(.DEPTH(2), .STARVE_LIMIT(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
        .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .wen_o(wen_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
        .pending_mask_o(pending_mask_o)
    );

    always #5 clk_i = ~clk_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (wen_o && (waddr_o != 5'd0)) begin
            rf[waddr_o] <= wdata_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid_i = v; alu_rd_i = rd; alu_data_i = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lsu_valid_i = v; lsu_rd_i = rd; lsu_data_i = d;
    endtask

    task automatic wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_wen"},   32'(wen_o),   32'(en));
        chk({tag, "_waddr"}, 32'(waddr_o), 32'(a));
        chk({tag, "_wdata"}, wdata_o,      d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        #3;
        wr("reset", 1'b0, 5'd0, 32'd0);
        chk("reset_pend", pending_mask_o, 32'd0);
        chk("reset_lsu_rdy", 32'(lsu_ready_o), 1);
        chk("reset_alu_rdy", 32'(alu_ready_o), 1);
        tick(); tick();
        #2 rst_ni = 1'b1;
        tick();

        // ALU-only write, then x0 discard
        alu(1'b1, 5'd5, 32'hDEADBEEF);
        chk("alu_rdy_x5", 32'(alu_ready_o), 1);
        tick();
        wr("alu_x5", 1'b1, 5'd5, 32'hDEADBEEF);
        alu(1'b1, 5'd0, 32'hFFFFFFFF);
        chk("alu_rdy_x0", 32'(alu_ready_o), 1);
        tick();
        wr("alu_x0", 1'b0, 5'd0, 32'd0);
        chk("rf_x5", rf[5], 32'hDEADBEEF);
        alu(1'b0, 5'd0, 32'd0);
        tick();
        wr("idle_hold", 1'b0, 5'd0, 32'd0);
        chk("rf_x0", rf[0], 32'd0);

        // Queue fill with ALU continuously valid, then starvation force
        alu(1'b1, 5'd1, 32'hA1);
        lsu(1'b1, 5'd7, 32'h11);
        tick();
        wr("fill_e1", 1'b1, 5'd1, 32'hA1);
        chk("fill_e1_pend", pending_mask_o, 32'h0000_0080);
        chk("fill_e1_rdy", 32'(lsu_ready_o), 1);
        alu(1'b1, 5'd2, 32'hA2);
        lsu(1'b1, 5'd8, 32'h22);
        tick();
        wr("fill_e2", 1'b1, 5'd2, 32'hA2);
        chk("full_rdy", 32'(lsu_ready_o), 0);
        chk("full_pend", pending_mask_o, 32'h0000_0180);
        lsu(1'b0, 5'd0, 32'd0);
        alu(1'b1, 5'd3, 32'hA3);
        tick();
        wr("starve_e3", 1'b1, 5'd3, 32'hA3);
        chk("starve_e3_alu_rdy", 32'(alu_ready_o), 1);
        alu(1'b1, 5'd4, 32'hA4);
        tick();
        wr("starve_e4", 1'b1, 5'd4, 32'hA4);
        chk("force_alu_rdy", 32'(alu_ready_o), 0);
        alu(1'b1, 5'd6, 32'hA6);
        tick();
        wr("forced_load", 1'b1, 5'd7, 32'h11);
        chk("pop1_lsu_rdy", 32'(lsu_ready_o), 1);
        chk("pop1_pend", pending_mask_o, 32'h0000_0100);
        chk("resume_alu_rdy", 32'(alu_ready_o), 1);
        tick();
        wr("alu_resume", 1'b1, 5'd6, 32'hA6);
        chk("rf_x7", rf[7], 32'h11);
        alu(1'b0, 5'd0, 32'd0);
        tick();
        wr("idle_load", 1'b1, 5'd8, 32'h22);
        chk("drain_pend", pending_mask_o, 32'd0);

        // Empty queue enqueue, then simultaneous pop + enqueue with ALU idle
        lsu(1'b1, 5'd9, 32'h33);
        tick();
        wr("enq_only", 1'b0, 5'd8, 32'h22);
        chk("enq_only_pend", pending_mask_o, 32'h0000_0200);
        lsu(1'b1, 5'd10, 32'h44);
        tick();
        wr("simul", 1'b1, 5'd9, 32'h33);
        chk("simul_pend", pending_mask_o, 32'h0000_0400);
        chk("simul_rdy", 32'(lsu_ready_o), 1);
        lsu(1'b0, 5'd0, 32'd0);
        tick();
        wr("simul_next", 1'b1, 5'd10, 32'h44);
        chk("simul_drain_pend", pending_mask_o, 32'd0);

        // Async reset mid-cycle with two loads queued
        alu(1'b1, 5'd11, 32'hB1);
        lsu(1'b1, 5'd12, 32'h55);
        tick();
        alu(1'b1, 5'd14, 32'hB2);
        lsu(1'b1, 5'd13, 32'h66);
        tick();
        wr("pre_rst", 1'b1, 5'd14, 32'hB2);
        chk("pre_rst_pend", pending_mask_o, 32'h0000_3000);
        chk("pre_rst_rdy", 32'(lsu_ready_o), 0);
        #2 rst_ni = 1'b0;
        #1;
        wr("async_rst", 1'b0, 5'd0, 32'd0);
        chk("async_rst_pend", pending_mask_o, 32'd0);
        chk("async_rst_rdy", 32'(lsu_ready_o), 1);
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        tick();
        #2 rst_ni = 1'b1;
        tick();
        wr("post_rst", 1'b0, 5'd0, 32'd0);
        chk("post_rst_pend", pending_mask_o, 32'd0);
        tick();
        chk("post_rst_wen2", 32'(wen_o), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
